// File: rtl/axi4_ddr_pkg.sv
// rtl/axi4_ddr_pkg.sv - shared codes and state encoding for the AXI4 to fifo-cache command front end
package axi4_ddr_pkg;

    typedef enum logic [1:0] {
        FIFO_IDE = 2'd0,
        FIFO_CMD = 2'd1,
        FIFO_WT  = 2'd2,
        FIFO_RD  = 2'd3
    } fifo_type_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_CMD  = 3'd3,
        ST_RD_DATA = 3'd4
    } state_e;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

    localparam int MAX_BURST = 64;

endpackage

// File: rtl/axi4_rd_outreg.sv
// rtl/axi4_rd_outreg.sv - one-entry AXI R channel output register
module axi4_rd_outreg #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_resp,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_resp,
    output logic                  o_last
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;

    // Load wins over drain so a handshake and refill in one cycle keeps the slot full
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= 2'b00;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_resp  <= i_resp;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_resp  = r_resp;
    assign o_last  = r_last;

endmodule

// File: rtl/axi4_cmd_gen.sv
// rtl/axi4_cmd_gen.sv - AXI4 INCR slave turning bursts into fifo-cache commands and R beats
module axi4_cmd_gen
    import axi4_ddr_pkg::*;
#(
    parameter int TYPE_WIDTH     = 2,
    parameter int ADDR_WIDTH     = 27,
    parameter int BRST_WIDTH     = 6,
    parameter int DATA_WIDTH     = 128,
    parameter int MASK_WIDTH     = 16,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ID_WIDTH       = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      io_axi_aw_valid,
    output logic                      io_axi_aw_ready,
    input  logic [ID_WIDTH-1:0]       io_axi_aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0] io_axi_aw_addr,
    input  logic [7:0]                io_axi_aw_len,
    input  logic                      io_axi_w_valid,
    output logic                      io_axi_w_ready,
    input  logic [DATA_WIDTH-1:0]     io_axi_w_data,
    input  logic [MASK_WIDTH-1:0]     io_axi_w_strb,
    input  logic                      io_axi_w_last,
    output logic                      io_axi_b_valid,
    input  logic                      io_axi_b_ready,
    output logic [ID_WIDTH-1:0]       io_axi_b_id,
    output logic [1:0]                io_axi_b_resp,
    input  logic                      io_axi_ar_valid,
    output logic                      io_axi_ar_ready,
    input  logic [ID_WIDTH-1:0]       io_axi_ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0] io_axi_ar_addr,
    input  logic [7:0]                io_axi_ar_len,
    output logic                      io_axi_r_valid,
    input  logic                      io_axi_r_ready,
    output logic [ID_WIDTH-1:0]       io_axi_r_id,
    output logic [DATA_WIDTH-1:0]     io_axi_r_data,
    output logic [1:0]                io_axi_r_resp,
    output logic                      io_axi_r_last,
    output logic                      io_fifo_cmd_valid,
    input  logic                      io_fifo_cmd_ready,
    output logic [TYPE_WIDTH-1:0]     io_fifo_cmd_type,
    output logic [ADDR_WIDTH-1:0]     io_fifo_cmd_addr,
    output logic [BRST_WIDTH-1:0]     io_fifo_cmd_burst_cnt,
    output logic [DATA_WIDTH-1:0]     io_fifo_cmd_wt_data,
    output logic [MASK_WIDTH-1:0]     io_fifo_cmd_wt_mask,
    output logic                      io_fifo_rsp_valid,
    input  logic                      io_fifo_rsp_ready,
    input  logic [DATA_WIDTH-1:0]     io_fifo_rsp_data
);

    state_e                  r_state;
    state_e                  w_state_nxt;
    grant_e                  r_last_grant;
    logic [ID_WIDTH-1:0]     r_id;
    logic [7:0]              r_len;
    logic                    r_err;
    logic [ADDR_WIDTH-1:0]   r_cmd_addr;
    logic [7:0]              r_beat_cnt;
    logic                    r_rd_done;

    logic                      w_grant_wr;
    logic                      w_grant_rd;
    logic                      w_aw_hs;
    logic                      w_ar_hs;
    logic [AXI_ADDR_WIDTH-1:0] w_req_addr;
    logic [7:0]                w_req_len;
    logic                      w_req_err;
    logic                      w_beat_is_last;
    logic                      w_w_ready;
    logic                      w_wr_beat;
    logic                      w_beats_left;
    logic                      w_slot_free;
    logic                      w_rd_load;
    logic [DATA_WIDTH-1:0]     w_load_data;
    logic [1:0]                w_err_resp;
    logic                      w_unused;

    // Alone wins; on a tie the side that did not win last time goes
    assign w_grant_wr = io_axi_aw_valid && (!io_axi_ar_valid || (r_last_grant == GRANT_READ));
    assign w_grant_rd = io_axi_ar_valid && (!io_axi_aw_valid || (r_last_grant == GRANT_WRITE));
    assign w_aw_hs    = (r_state == ST_IDLE) && w_grant_wr;
    assign w_ar_hs    = (r_state == ST_IDLE) && w_grant_rd;

    assign w_req_addr = w_aw_hs ? io_axi_aw_addr : io_axi_ar_addr;
    assign w_req_len  = w_aw_hs ? io_axi_aw_len : io_axi_ar_len;
    assign w_req_err  = (w_req_len > 8'(MAX_BURST - 1));

    assign w_beat_is_last = (r_beat_cnt == r_len);
    assign w_err_resp     = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    // Oversized write bursts are swallowed without touching the fifo
    assign w_w_ready = r_err ? 1'b1 : io_fifo_cmd_ready;
    assign w_wr_beat = (r_state == ST_WR_DATA) && io_axi_w_valid && w_w_ready;

    assign w_beats_left = !r_rd_done;
    assign w_slot_free  = !io_axi_r_valid || io_axi_r_ready;
    assign w_rd_load    = (r_state == ST_RD_DATA) && w_beats_left && w_slot_free
                          && (r_err || io_fifo_rsp_ready);
    assign w_load_data  = r_err ? '0 : io_fifo_rsp_data;

    // Bits of the byte address below 128-bit alignment or above the DDR range carry no meaning here
    assign w_unused = ^{io_axi_w_last, w_req_addr[3:0], w_req_addr[AXI_ADDR_WIDTH-1:ADDR_WIDTH+1]};

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state handshake/command outputs
    always_comb begin
        w_state_nxt         = r_state;
        io_axi_aw_ready     = 1'b0;
        io_axi_ar_ready     = 1'b0;
        io_axi_w_ready      = 1'b0;
        io_axi_b_valid      = 1'b0;
        io_fifo_cmd_valid   = 1'b0;
        io_fifo_cmd_type    = TYPE_WIDTH'(FIFO_IDE);
        io_fifo_cmd_wt_data = '0;
        io_fifo_cmd_wt_mask = '1;
        io_fifo_rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                io_axi_aw_ready = w_grant_wr;
                io_axi_ar_ready = w_grant_rd;
                if (w_grant_wr) begin
                    w_state_nxt = ST_WR_DATA;
                end else if (w_grant_rd) begin
                    w_state_nxt = w_req_err ? ST_RD_DATA : ST_RD_CMD;
                end
            end
            ST_WR_DATA: begin
                io_fifo_cmd_valid   = io_axi_w_valid && !r_err;
                io_axi_w_ready      = w_w_ready;
                io_fifo_cmd_type    = TYPE_WIDTH'(FIFO_WT);
                io_fifo_cmd_wt_data = io_axi_w_data;
                io_fifo_cmd_wt_mask = ~io_axi_w_strb;
                if (w_wr_beat && w_beat_is_last) begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                io_axi_b_valid = 1'b1;
                if (io_axi_b_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_CMD: begin
                io_fifo_cmd_valid = 1'b1;
                io_fifo_cmd_type  = TYPE_WIDTH'(FIFO_RD);
                if (io_fifo_cmd_ready) begin
                    w_state_nxt = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                io_fifo_rsp_valid = w_beats_left && w_slot_free && !r_err;
                if (io_axi_r_valid && io_axi_r_ready && io_axi_r_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Transaction context capture and beat counting
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_grant <= GRANT_READ;
            r_id         <= '0;
            r_len        <= 8'd0;
            r_err        <= 1'b0;
            r_cmd_addr   <= '0;
            r_beat_cnt   <= 8'd0;
            r_rd_done    <= 1'b0;
        end else if (w_aw_hs || w_ar_hs) begin
            r_last_grant <= w_aw_hs ? GRANT_WRITE : GRANT_READ;
            r_id         <= w_aw_hs ? io_axi_aw_id : io_axi_ar_id;
            r_len        <= w_req_len;
            r_err        <= w_req_err;
            r_cmd_addr   <= {w_req_addr[ADDR_WIDTH:4], 3'b000};
            r_beat_cnt   <= 8'd0;
            r_rd_done    <= 1'b0;
        end else if (w_wr_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end else if (w_rd_load) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_beat_is_last) begin
                r_rd_done <= 1'b1;
            end
        end
    end

    assign io_fifo_cmd_addr      = r_cmd_addr;
    assign io_fifo_cmd_burst_cnt = r_len[BRST_WIDTH-1:0];
    assign io_axi_b_id           = r_id;
    assign io_axi_b_resp         = w_err_resp;
    assign io_axi_r_id           = r_id;

    axi4_rd_outreg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_outreg (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_rd_load),
        .i_data  (w_load_data),
        .i_resp  (w_err_resp),
        .i_last  (w_beat_is_last),
        .i_ready (io_axi_r_ready),
        .o_valid (io_axi_r_valid),
        .o_data  (io_axi_r_data),
        .o_resp  (io_axi_r_resp),
        .o_last  (io_axi_r_last)
    );

endmodule

// File: tb/tb_axi4_cmd_gen.sv
// tb/tb_axi4_cmd_gen.sv - self-checking bench for axi4_cmd_gen
module tb_axi4_cmd_gen;

    logic         clk;
    logic         rstn;
    logic         aw_valid, aw_ready;
    logic [3:0]   aw_id;
    logic [31:0]  aw_addr;
    logic [7:0]   aw_len;
    logic         w_valid, w_ready;
    logic [127:0] w_data;
    logic [15:0]  w_strb;
    logic         w_last;
    logic         b_valid, b_ready;
    logic [3:0]   b_id;
    logic [1:0]   b_resp;
    logic         ar_valid, ar_ready;
    logic [3:0]   ar_id;
    logic [31:0]  ar_addr;
    logic [7:0]   ar_len;
    logic         r_valid, r_ready;
    logic [3:0]   r_id;
    logic [127:0] r_data;
    logic [1:0]   r_resp;
    logic         r_last;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_type;
    logic [26:0]  cmd_addr;
    logic [5:0]   cmd_burst;
    logic [127:0] cmd_wt_data;
    logic [15:0]  cmd_wt_mask;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_data;

    int checks;
    int errors;
    bit last_was_read;
    int n0;
    int rlen;
    logic [31:0] raddr;

    initial clk = 1'b0;
    always #20 clk = ~clk;

    axi4_cmd_gen dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .io_axi_aw_valid       (aw_valid),
        .io_axi_aw_ready       (aw_ready),
        .io_axi_aw_id          (aw_id),
        .io_axi_aw_addr        (aw_addr),
        .io_axi_aw_len         (aw_len),
        .io_axi_w_valid        (w_valid),
        .io_axi_w_ready        (w_ready),
        .io_axi_w_data         (w_data),
        .io_axi_w_strb         (w_strb),
        .io_axi_w_last         (w_last),
        .io_axi_b_valid        (b_valid),
        .io_axi_b_ready        (b_ready),
        .io_axi_b_id           (b_id),
        .io_axi_b_resp         (b_resp),
        .io_axi_ar_valid       (ar_valid),
        .io_axi_ar_ready       (ar_ready),
        .io_axi_ar_id          (ar_id),
        .io_axi_ar_addr        (ar_addr),
        .io_axi_ar_len         (ar_len),
        .io_axi_r_valid        (r_valid),
        .io_axi_r_ready        (r_ready),
        .io_axi_r_id           (r_id),
        .io_axi_r_data         (r_data),
        .io_axi_r_resp         (r_resp),
        .io_axi_r_last         (r_last),
        .io_fifo_cmd_valid     (cmd_valid),
        .io_fifo_cmd_ready     (cmd_ready),
        .io_fifo_cmd_type      (cmd_type),
        .io_fifo_cmd_addr      (cmd_addr),
        .io_fifo_cmd_burst_cnt (cmd_burst),
        .io_fifo_cmd_wt_data   (cmd_wt_data),
        .io_fifo_cmd_wt_mask   (cmd_wt_mask),
        .io_fifo_rsp_valid     (rsp_valid),
        .io_fifo_rsp_ready     (rsp_ready),
        .io_fifo_rsp_data      (rsp_data)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [26:0] ddr_addr(input logic [31:0] byte_addr);
        longint a;
        a = (longint'(byte_addr) / 16) * 8;
        return 27'(a);
    endfunction

    // mode: 0 random cmd_ready, 1 toggling starting high, 2 always ready
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int mode, input bit use_strb, input logic [15:0] fixed_strb);
        bit err;
        logic [26:0] exp_addr;
        int n;
        int beat;
        logic [127:0] d;
        logic [15:0] s;
        logic [15:0] ms;
        err = (len > 63);
        exp_addr = ddr_addr(addr);
        last_was_read = 1'b0;
        @(negedge clk);
        aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = 8'(len);
        #1;
        n = 0;
        while (!aw_ready && n < 50) begin @(negedge clk); #1; n++; end
        check("aw_ready", 128'(aw_ready), 128'(1));
        @(negedge clk);
        aw_valid = 1'b0;
        beat = 0; n = 0;
        d = rand128();
        s = use_strb ? fixed_strb : 16'($urandom);
        while (beat <= len && n < 4000) begin
            w_valid = 1'b1; w_data = d; w_strb = s; w_last = (beat == len);
            if (mode == 1)      cmd_ready = (n % 2 == 0);
            else if (mode == 2) cmd_ready = 1'b1;
            else                cmd_ready = 1'($urandom_range(0, 1));
            #1;
            if (err) begin
                check("wr_err_cmd_valid", 128'(cmd_valid), 128'(0));
                check("wr_err_w_ready", 128'(w_ready), 128'(1));
            end else begin
                ms = ~s;
                check("wr_cmd_valid", 128'(cmd_valid), 128'(1));
                check("wr_cmd_type", 128'(cmd_type), 128'(2));
                check("wr_cmd_addr", 128'(cmd_addr), 128'(exp_addr));
                check("wr_burst_cnt", 128'(cmd_burst), 128'(len % 64));
                check("wr_data", cmd_wt_data, d);
                check("wr_mask", 128'(cmd_wt_mask), 128'(ms));
                check("wr_w_ready", 128'(w_ready), 128'(cmd_ready));
            end
            if (w_ready) begin
                beat++;
                d = rand128();
                s = use_strb ? fixed_strb : 16'($urandom);
            end
            @(negedge clk);
            n++;
        end
        check("wr_beats", 128'(beat), 128'(len + 1));
        w_valid = 1'b0; w_last = 1'b0; cmd_ready = 1'b0;
        b_ready = 1'($urandom_range(0, 1));
        #1;
        check("b_latency", 128'(b_valid), 128'(1));
        n = 0;
        while (!(b_valid && b_ready) && n < 50) begin
            @(negedge clk);
            b_ready = 1'($urandom_range(0, 1));
            #1;
            n++;
        end
        check("b_handshake", 128'(b_valid && b_ready), 128'(1));
        check("b_resp", 128'(b_resp), 128'(err ? 2 : 0));
        check("b_id", 128'(b_id), 128'(id));
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input bit fast, input bit seq);
        bit err;
        logic [26:0] exp_addr;
        int n;
        int got;
        int pops;
        bit done;
        bit expect_rv;
        bit hold;
        logic [127:0] hold_data;
        logic [127:0] ev;
        logic [127:0] words[$];
        logic [127:0] exp_r[$];
        err = (len > 63);
        exp_addr = ddr_addr(addr);
        last_was_read = 1'b1;
        @(negedge clk);
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = 8'(len);
        #1;
        n = 0;
        while (!ar_ready && n < 50) begin @(negedge clk); #1; n++; end
        check("ar_ready", 128'(ar_ready), 128'(1));
        @(negedge clk);
        ar_valid = 1'b0;
        if (!err) begin
            done = 1'b0; n = 0;
            while (!done && n < 50) begin
                cmd_ready = fast ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                check("rd_cmd_valid", 128'(cmd_valid), 128'(1));
                check("rd_cmd_type", 128'(cmd_type), 128'(3));
                check("rd_cmd_addr", 128'(cmd_addr), 128'(exp_addr));
                check("rd_burst_cnt", 128'(cmd_burst), 128'(len % 64));
                check("rd_wt_data", cmd_wt_data, 128'(0));
                check("rd_wt_mask", 128'(cmd_wt_mask), 128'(16'hFFFF));
                done = cmd_valid && cmd_ready;
                @(negedge clk);
                n++;
            end
            check("rd_cmd_accepted", 128'(done), 128'(1));
            cmd_ready = 1'b0;
            for (int i = 0; i <= len; i++) words.push_back(seq ? 128'(i) : rand128());
        end
        got = 0; pops = 0; expect_rv = 1'b0; hold = 1'b0; hold_data = '0; n = 0;
        while (got <= len && n < 5000) begin
            rsp_data = (words.size() > 0) ? words[0] : rand128();
            if (err || pops > len) rsp_ready = 1'b1;
            else                   rsp_ready = fast ? 1'b1 : 1'($urandom_range(0, 1));
            r_ready = fast ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            check("rd_no_cmd", 128'(cmd_valid), 128'(0));
            if (err) check("rd_err_no_pop", 128'(rsp_valid), 128'(0));
            if (expect_rv) check("r_pop_latency", 128'(r_valid), 128'(1));
            if (hold) check("r_stable", r_data, hold_data);
            if (fast && got > 0) check("r_throughput", 128'(r_valid), 128'(1));
            expect_rv = 1'b0;
            if (rsp_valid && rsp_ready) begin
                pops++;
                check("rd_pop_count", 128'(pops <= len + 1), 128'(1));
                if (words.size() > 0) exp_r.push_back(words.pop_front());
                expect_rv = 1'b1;
            end
            if (r_valid && r_ready) begin
                if (err)                 ev = '0;
                else if (exp_r.size() > 0) ev = exp_r.pop_front();
                else                     ev = 'x;
                check("r_data", r_data, ev);
                check("r_resp", 128'(r_resp), 128'(err ? 2 : 0));
                check("r_last", 128'(r_last), 128'(got == len));
                check("r_id", 128'(r_id), 128'(id));
                got++;
            end
            hold = r_valid && !r_ready;
            hold_data = r_data;
            @(negedge clk);
            n++;
        end
        check("rd_beats", 128'(got), 128'(len + 1));
        r_ready = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic tie_check();
        bit exp_wr;
        exp_wr = last_was_read;
        @(negedge clk);
        aw_valid = 1'b1; ar_valid = 1'b1; aw_len = 8'd0; ar_len = 8'd0;
        #1;
        check("tie_aw_ready", 128'(aw_ready), 128'(exp_wr));
        check("tie_ar_ready", 128'(ar_ready), 128'(!exp_wr));
        aw_valid = 1'b0; ar_valid = 1'b0;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; last_was_read = 1'b1;
        rstn = 1'b0;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
        b_ready = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0;
        r_ready = 0; cmd_ready = 0; rsp_ready = 0; rsp_data = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_valid", 128'(cmd_valid), 128'(0));
        check("rst_b_valid", 128'(b_valid), 128'(0));
        check("rst_r_valid", 128'(r_valid), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_w_ready", 128'(w_ready), 128'(0));
        check("rst_r_data", r_data, 128'(0));
        aw_valid = 1'b1;
        #1;
        check("rst_aw_ready", 128'(aw_ready), 128'(1));
        check("rst_ar_ready", 128'(ar_ready), 128'(0));
        aw_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        do_write(4'h5, 32'h0000_0100, 0, 2, 1'b1, 16'h00FF);
        do_write(4'hA, 32'h1234_5670, 3, 1, 1'b0, 16'h0000);
        do_read(4'h3, 32'h2000_0040, 7, 1'b0, 1'b1);

        tie_check();
        do_write(4'h1, 32'h0000_8000, 2, 0, 1'b0, 16'h0000);
        tie_check();
        do_read(4'h2, 32'h0000_8000, 4, 1'b1, 1'b0);
        tie_check();

        do_read(4'h7, 32'h0000_0040, 64, 1'b0, 1'b0);
        do_write(4'h9, 32'h0000_0080, 100, 0, 1'b0, 16'h0000);
        do_read(4'hE, 32'hFFFF_FFF0, 15, 1'b1, 1'b0);
        do_read(4'h6, 32'h0000_1000, 63, 1'b1, 1'b0);

        @(negedge clk);
        aw_valid = 1'b1; aw_id = 4'hC; aw_addr = 32'h300; aw_len = 8'd7;
        #1;
        n0 = 0;
        while (!aw_ready && n0 < 50) begin @(negedge clk); #1; n0++; end
        check("mid_aw_ready", 128'(aw_ready), 128'(1));
        @(negedge clk);
        aw_valid = 1'b0;
        repeat (3) begin
            w_valid = 1'b1; w_data = rand128(); w_strb = 16'hFFFF; cmd_ready = 1'b1;
            @(negedge clk);
        end
        w_valid = 1'b1; cmd_ready = 1'b1;
        #1;
        check("mid_cmd_valid_before", 128'(cmd_valid), 128'(1));
        rstn = 1'b0;
        #1;
        check("mid_cmd_valid_reset", 128'(cmd_valid), 128'(0));
        check("mid_w_ready_reset", 128'(w_ready), 128'(0));
        check("mid_b_valid_reset", 128'(b_valid), 128'(0));
        check("mid_r_valid_reset", 128'(r_valid), 128'(0));
        check("mid_rsp_valid_reset", 128'(rsp_valid), 128'(0));
        w_valid = 1'b0; cmd_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        last_was_read = 1'b1;
        do_write(4'hD, 32'h0000_0400, 1, 2, 1'b0, 16'h0000);

        for (int k = 0; k < 12; k++) begin
            rlen = ($urandom_range(0, 7) == 0) ? 64 + $urandom_range(0, 8) : $urandom_range(0, 20);
            raddr = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(4'($urandom), raddr, rlen, $urandom_range(0, 2), 1'b0, 16'h0000);
            else
                do_read(4'($urandom), raddr, rlen, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
